// File: rtl/rng_sequencer_pkg.sv
// rng_pkg: shared defaults and width helper for the random-digit sequencer
package rng_pkg;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/rng_sequencer_lfsr_gen.sv
// lfsr_gen: free-running Galois LFSR whose reset state is never zero
module lfsr_gen #(
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);
    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_W'(1) : SEED;
    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else state <= (state >> 1) ^ ({LFSR_W{state[0]}} & TAPS);
    end
endmodule

// File: rtl/rng_sequencer.sv
// rng_sequencer: captures LFSR digits on authorised presses and plays them back in order
module rng_sequencer import rng_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        button_pulse,
    input  logic                        auth_bit,
    input  logic                        clear,
    input  logic                        rd_en,
    input  logic                        rd_rewind,
    output logic [WIDTH-1:0]            random_num,
    output logic                        enable,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid,
    output logic [count_w(DEPTH)-1:0]   count,
    output logic                        full,
    output logic                        empty
);
    localparam int CW = count_w(DEPTH);
    localparam int AW = $clog2(DEPTH);
    logic [LFSR_W-1:0] lfsr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [CW-1:0]     rd_ptr;
    logic [WIDTH-1:0]  digit;
    logic              cap, rd_ok;
    lfsr_gen #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
        .clk(clk),
        .rst(rst),
        .state(lfsr)
    );
    always_comb begin
        digit = lfsr[WIDTH-1:0];
        full  = count == CW'(DEPTH);
        empty = count == '0;
        cap   = button_pulse & auth_bit & ~full & ~clear;
        rd_ok = rd_en & ~rd_rewind & ~clear & (rd_ptr < count);
    end
    always_ff @(posedge clk) begin
        if (cap) mem[count[AW-1:0]] <= digit;
    end
    // reads compare against the pre-capture count, so a same-cycle write is never returned
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            rd_ptr     <= '0;
            random_num <= '0;
            enable     <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            enable   <= cap;
            rd_valid <= rd_ok;
            if (cap) random_num <= digit;
            if (rd_ok) rd_data <= mem[rd_ptr[AW-1:0]];
            if (clear) begin
                count  <= '0;
                rd_ptr <= '0;
            end else begin
                if (cap) count <= count + CW'(1);
                if (rd_rewind) rd_ptr <= '0;
                else if (rd_ok) rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rng_sequencer.sv
// tb_rng_sequencer: directed checks of capture, playback, priority, reset and zero-seed LFSR
module tb_rng_sequencer;
    logic clk = 0, rst = 1, button_pulse = 0, auth_bit = 0, clear = 0, rd_en = 0, rd_rewind = 0;
    logic [3:0] random_num, rd_data, count;
    logic       enable, rd_valid, full, empty;
    logic [2:0] z_rn, z_rd;
    logic [3:0] z_count;
    logic       z_en, z_rv, z_full, z_empty;
    int checks = 0, errors = 0;
    logic [15:0] model, pre;
    logic [3:0]  d [8];
    int period, zeros;

    rng_sequencer dut (
        .clk(clk), .rst(rst), .button_pulse(button_pulse), .auth_bit(auth_bit),
        .clear(clear), .rd_en(rd_en), .rd_rewind(rd_rewind), .random_num(random_num),
        .enable(enable), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .full(full), .empty(empty)
    );

    rng_sequencer #(.WIDTH(3), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'h00), .DEPTH(8)) dut2 (
        .clk(clk), .rst(rst), .button_pulse(1'b0), .auth_bit(1'b0),
        .clear(1'b0), .rd_en(1'b0), .rd_rewind(1'b0), .random_num(z_rn),
        .enable(z_en), .rd_data(z_rd), .rd_valid(z_rv), .count(z_count),
        .full(z_full), .empty(z_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] x);
        return (x >> 1) ^ ({16{x[0]}} & 16'hB400);
    endfunction

    task automatic tick();
        pre = model;
        model = rst ? 16'hACE1 : nxt(model);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rn"}, 32'(random_num), 0);
        chk({tag, "_en"}, 32'(enable), 0);
        chk({tag, "_rd"}, 32'(rd_data), 0);
        chk({tag, "_rv"}, 32'(rd_valid), 0);
        chk({tag, "_cnt"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
    endtask

    initial begin
        tick();
        tick();
        check_reset_outputs("rst");
        // first captures straight out of reset
        rst = 0; button_pulse = 1; auth_bit = 1;
        tick();
        chk("cap1_en", 32'(enable), 1);
        chk("cap1_rn", 32'(random_num), 32'h1);
        chk("cap1_cnt", 32'(count), 1);
        tick();
        chk("cap2_rn", 32'(random_num), 32'h0);
        chk("cap2_cnt", 32'(count), 2);
        chk("lfsr_track", 32'(dut.u_lfsr.state), 32'(model));
        button_pulse = 0;
        tick();
        chk("idle_en", 32'(enable), 0);
        // auth gating
        clear = 1; tick(); clear = 0;
        auth_bit = 0;
        for (int i = 0; i < 3; i++) begin
            button_pulse = 1; tick();
            chk("noauth_en", 32'(enable), 0);
            button_pulse = 0; tick();
        end
        chk("noauth_cnt", 32'(count), 0);
        // fill the buffer, ninth press dropped
        auth_bit = 1; button_pulse = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("fill_en", 32'(enable), i < 8 ? 1 : 0);
            if (i < 8) begin
                d[i] = pre[3:0];
                chk("fill_rn", 32'(random_num), 32'(d[i]));
            end
        end
        chk("full_rn_hold", 32'(random_num), 32'(d[7]));
        chk("full_cnt", 32'(count), 8);
        chk("full_flag", 32'(full), 1);
        button_pulse = 0;
        // playback of three digits
        clear = 1; tick(); clear = 0;
        chk("clear_empty", 32'(empty), 1);
        button_pulse = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            d[i] = pre[3:0];
        end
        button_pulse = 0; rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("play_rv", 32'(rd_valid), i < 3 ? 1 : 0);
            chk("play_rd", 32'(rd_data), 32'(i < 3 ? d[i] : d[2]));
        end
        chk("play_cnt", 32'(count), 3);
        rd_en = 0; rd_rewind = 1; tick(); rd_rewind = 0;
        rd_en = 1; tick();
        chk("rewind_rv", 32'(rd_valid), 1);
        chk("rewind_rd", 32'(rd_data), 32'(d[0]));
        rd_rewind = 1; tick(); rd_rewind = 0;
        chk("rw_rd_rv", 32'(rd_valid), 0);
        chk("rw_rd_ptr", 32'(dut.rd_ptr), 0);
        tick();
        chk("rw_again_rd", 32'(rd_data), 32'(d[0]));
        rd_en = 0;
        // clear beats capture
        clear = 1; button_pulse = 1; tick(); clear = 0; button_pulse = 0;
        chk("clrcap_cnt", 32'(count), 0);
        chk("clrcap_en", 32'(enable), 0);
        // capture and read together on an empty buffer
        button_pulse = 1; rd_en = 1; tick();
        d[0] = pre[3:0];
        chk("sim_empty_rv", 32'(rd_valid), 0);
        chk("sim_empty_en", 32'(enable), 1);
        tick();
        d[1] = pre[3:0];
        chk("sim_rv", 32'(rd_valid), 1);
        chk("sim_rd", 32'(rd_data), 32'(d[0]));
        chk("sim_cnt", 32'(count), 2);
        button_pulse = 0; tick();
        chk("sim_rd2", 32'(rd_data), 32'(d[1]));
        rd_en = 0;
        // reset mid-sequence
        clear = 1; tick(); clear = 0;
        button_pulse = 1;
        for (int i = 0; i < 5; i++) tick();
        button_pulse = 0; rd_en = 1; tick(); tick(); rd_en = 0;
        rst = 1; tick(); rst = 0;
        check_reset_outputs("midrst");
        chk("midrst_lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
        button_pulse = 1; tick(); button_pulse = 0;
        chk("midrst_cap_rn", 32'(random_num), 32'h1);
        // zero-seed instance: starts at 1, never 0, period 255
        rst = 1; tick(); rst = 0;
        chk("z_start", 32'(dut2.u_lfsr.state), 1);
        period = 0; zeros = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (dut2.u_lfsr.state == 8'h00) zeros++;
            if (dut2.u_lfsr.state == 8'h01 && period == 0) period = i;
        end
        chk("z_nonzero", 32'(zeros), 0);
        chk("z_period", 32'(period), 255);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
